// File: rtl/otter_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the OTTER fetch queue.
// The queue takes the slave view; the fetch/decode side takes the master view.
interface otter_fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            FLUSH;
    logic            IF_VALID;
    logic [XLEN-1:0] IF_PC;
    logic [31:0]     IF_IR;
    logic            IF_READY;
    logic            DE_VALID;
    logic [XLEN-1:0] DE_PC;
    logic [31:0]     DE_IR;
    logic            DE_READY;
    logic [CW-1:0]   COUNT;
    logic            OVF_ERR;

    modport slave (
        input  FLUSH, IF_VALID, IF_PC, IF_IR, DE_READY,
        output IF_READY, DE_VALID, DE_PC, DE_IR, COUNT, OVF_ERR
    );

    modport master (
        output FLUSH, IF_VALID, IF_PC, IF_IR, DE_READY,
        input  IF_READY, DE_VALID, DE_PC, DE_IR, COUNT, OVF_ERR
    );
endinterface

// File: rtl/otter_fetch_queue.sv
// Instruction queue between Fetch and Decode: circular buffer of {pc, ir} with
// wrap-bit pointers, flush on redirect, optional empty-queue bypass, sticky overflow flag.
module otter_fetch_queue #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned BYPASS = 0
) (
    input  logic                CLK,
    input  logic                RESET,
    otter_fetch_queue_if.slave  fq
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PW     = AW + 1;
    localparam logic [31:0] NOP_IR = 32'h0000_0013;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("otter_fetch_queue: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW-1:0]   wr_ptr_nxt, rd_ptr_nxt;
    logic            ovf_err, ovf_err_nxt;
    logic [XLEN-1:0] mem_pc [DEPTH];
    logic [31:0]     mem_ir [DEPTH];

    logic full_c, empty_c, bypass_c, ready_c, valid_c, push_c, pop_c;

    // Handshake qualification; bypass traffic never touches the pointers.
    always_comb begin
        empty_c  = (wr_ptr == rd_ptr);
        full_c   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        bypass_c = (BYPASS != 0) && empty_c && fq.IF_VALID && fq.DE_READY && !fq.FLUSH;
        ready_c  = !full_c || fq.DE_READY;
        valid_c  = (!empty_c || bypass_c) && !fq.FLUSH;
        push_c   = fq.IF_VALID && ready_c && !fq.FLUSH && !bypass_c;
        pop_c    = valid_c && fq.DE_READY && !bypass_c;
    end

    // Next-state: flush clears both pointers; the extra MSB acts as the wrap bit.
    always_comb begin
        wr_ptr_nxt  = wr_ptr;
        rd_ptr_nxt  = rd_ptr;
        ovf_err_nxt = ovf_err;
        if (fq.FLUSH) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (push_c) wr_ptr_nxt = wr_ptr + PW'(1);
            if (pop_c)  rd_ptr_nxt = rd_ptr + PW'(1);
        end
        if (fq.IF_VALID && !ready_c && !fq.FLUSH) ovf_err_nxt = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf_err <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            ovf_err <= ovf_err_nxt;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem_pc[wr_ptr[AW-1:0]] <= fq.IF_PC;
            mem_ir[wr_ptr[AW-1:0]] <= fq.IF_IR;
        end
    end

    assign fq.IF_READY = ready_c;
    assign fq.DE_VALID = valid_c;
    assign fq.DE_PC    = bypass_c ? fq.IF_PC : mem_pc[rd_ptr[AW-1:0]];
    assign fq.DE_IR    = !valid_c ? NOP_IR : (bypass_c ? fq.IF_IR : mem_ir[rd_ptr[AW-1:0]]);
    assign fq.COUNT    = wr_ptr - rd_ptr;
    assign fq.OVF_ERR  = ovf_err;

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue: one queue without bypass, one with bypass.
module tb_otter_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic CLK;
    logic RESET;
    int   n_checks;
    int   n_errors;

    otter_fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus0 ();
    otter_fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus1 ();

    otter_fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .fq(bus0.slave)
    );
    otter_fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .fq(bus1.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Instruction word tagged with its PC so IR mix-ups are visible.
    task automatic drive0(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        bus0.IF_VALID = v;
        bus0.IF_PC    = pc;
        bus0.IF_IR    = 32'hA000_0000 | pc;
        bus0.DE_READY = rdy;
        bus0.FLUSH    = fl;
        #1;
    endtask

    task automatic drive1(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                          input logic rdy, input logic fl);
        bus1.IF_VALID = v;
        bus1.IF_PC    = pc;
        bus1.IF_IR    = ir;
        bus1.DE_READY = rdy;
        bus1.FLUSH    = fl;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_pc [4];
        n_checks = 0;
        n_errors = 0;
        CLK   = 1'b0;
        RESET = 1'b1;
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        tick();
        tick();
        RESET = 1'b0;
        #1;

        // Reset state
        check("rst_count",  64'(bus0.COUNT), 0);
        check("rst_valid",  64'(bus0.DE_VALID), 0);
        check("rst_ir",     64'(bus0.DE_IR), 64'(NOP));
        check("rst_ready",  64'(bus0.IF_READY), 1);
        check("rst_ovf",    64'(bus0.OVF_ERR), 0);
        check("rst_valid1", 64'(bus1.DE_VALID), 0);

        // Three pushes while Decode stalls, then drain in order
        for (int i = 0; i < 3; i++) begin
            drive0(1, 32'(4 * i), 0, 0);
            if (i == 0) check("latency_valid", 64'(bus0.DE_VALID), 0);
            tick();
        end
        drive0(0, 0, 0, 0);
        check("fill3_count", 64'(bus0.COUNT), 3);
        check("stall_pc_a", 64'(bus0.DE_PC), 0);
        tick();
        check("stall_pc_b", 64'(bus0.DE_PC), 0);
        for (int i = 0; i < 3; i++) begin
            drive0(0, 0, 1, 0);
            check("pop_valid", 64'(bus0.DE_VALID), 1);
            check("pop_pc", 64'(bus0.DE_PC), 64'(4 * i));
            check("pop_ir", 64'(bus0.DE_IR), 64'(32'hA000_0000 | 32'(4 * i)));
            tick();
        end
        drive0(0, 0, 1, 0);
        check("drain_valid", 64'(bus0.DE_VALID), 0);
        check("drain_ir",    64'(bus0.DE_IR), 64'(NOP));
        check("drain_count", 64'(bus0.COUNT), 0);

        // Fill, overflow attempt, then push into full queue with simultaneous pop
        for (int i = 0; i < 4; i++) begin
            drive0(1, 32'(4 * i), 0, 0);
            tick();
        end
        drive0(1, 32'h10, 0, 0);
        check("full_ready", 64'(bus0.IF_READY), 0);
        check("full_count", 64'(bus0.COUNT), 4);
        tick();
        drive0(0, 0, 0, 0);
        check("ovf_set",   64'(bus0.OVF_ERR), 1);
        check("ovf_count", 64'(bus0.COUNT), 4);
        drive0(1, 32'h14, 1, 0);
        check("full_pop_ready", 64'(bus0.IF_READY), 1);
        check("full_pop_pc",    64'(bus0.DE_PC), 0);
        tick();
        drive0(0, 0, 1, 0);
        check("full_pushpop_count", 64'(bus0.COUNT), 4);
        exp_pc[0] = 32'h04; exp_pc[1] = 32'h08; exp_pc[2] = 32'h0C; exp_pc[3] = 32'h14;
        for (int i = 0; i < 4; i++) begin
            drive0(0, 0, 1, 0);
            check("ovf_drain_pc", 64'(bus0.DE_PC), 64'(exp_pc[i]));
            tick();
        end
        check("ovf_drain_count", 64'(bus0.COUNT), 0);
        check("ovf_sticky",      64'(bus0.OVF_ERR), 1);

        // Flush with coincident push and pop
        for (int i = 0; i < 3; i++) begin
            drive0(1, 32'h20 + 32'(4 * i), 0, 0);
            tick();
        end
        drive0(0, 0, 0, 0);
        check("pre_flush_count", 64'(bus0.COUNT), 3);
        drive0(1, 32'h40, 1, 1);
        check("flush_valid", 64'(bus0.DE_VALID), 0);
        check("flush_ir",    64'(bus0.DE_IR), 64'(NOP));
        tick();
        drive0(0, 0, 1, 0);
        check("post_flush_count", 64'(bus0.COUNT), 0);
        check("post_flush_ready", 64'(bus0.IF_READY), 1);
        check("post_flush_valid", 64'(bus0.DE_VALID), 0);
        check("flush_ovf_kept",   64'(bus0.OVF_ERR), 1);
        tick();
        check("flush_no_0x40", 64'(bus0.DE_VALID), 0);

        // Ten back-to-back push+pop cycles at COUNT=2 across pointer wrap
        drive0(1, 32'h50, 0, 0);
        tick();
        drive0(1, 32'h54, 0, 0);
        tick();
        drive0(0, 0, 0, 0);
        check("wrap_start_count", 64'(bus0.COUNT), 2);
        for (int i = 0; i < 10; i++) begin
            drive0(1, 32'h58 + 32'(4 * i), 1, 0);
            check("wrap_pc", 64'(bus0.DE_PC), 64'(32'h50 + 32'(4 * i)));
            tick();
            check("wrap_count", 64'(bus0.COUNT), 2);
        end
        for (int i = 0; i < 2; i++) begin
            drive0(0, 0, 1, 0);
            check("wrap_drain_pc", 64'(bus0.DE_PC), 64'(32'h78 + 32'(4 * i)));
            tick();
        end
        check("wrap_end_count", 64'(bus0.COUNT), 0);

        // Reset overrides everything, including a coincident push and flush
        for (int i = 0; i < 4; i++) begin
            drive0(1, 32'h80 + 32'(4 * i), 0, 0);
            tick();
        end
        drive0(1, 32'h90, 0, 0);
        tick();
        drive0(0, 0, 1, 0);
        tick();
        drive0(0, 0, 0, 0);
        check("pre_rst_count", 64'(bus0.COUNT), 3);
        check("pre_rst_ovf",   64'(bus0.OVF_ERR), 1);
        RESET = 1'b1;
        drive0(1, 32'hA0, 1, 1);
        tick();
        RESET = 1'b0;
        drive0(0, 0, 0, 0);
        check("rst2_count", 64'(bus0.COUNT), 0);
        check("rst2_ovf",   64'(bus0.OVF_ERR), 0);
        check("rst2_valid", 64'(bus0.DE_VALID), 0);
        check("rst2_ready", 64'(bus0.IF_READY), 1);
        check("rst2_ir",    64'(bus0.DE_IR), 64'(NOP));
        tick();
        check("rst2_push_lost", 64'(bus0.COUNT), 0);

        // Bypass instance: same-cycle pass-through when empty
        drive1(1, 32'h100, 32'h0050_0093, 1, 0);
        check("byp_valid", 64'(bus1.DE_VALID), 1);
        check("byp_pc",    64'(bus1.DE_PC), 64'h100);
        check("byp_ir",    64'(bus1.DE_IR), 64'h0050_0093);
        check("byp_count", 64'(bus1.COUNT), 0);
        tick();
        drive1(0, 0, 0, 0, 0);
        check("byp_not_stored", 64'(bus1.COUNT), 0);
        check("byp_idle_valid", 64'(bus1.DE_VALID), 0);

        // Bypass blocked by stall: stored normally
        drive1(1, 32'h104, 32'h0010_0113, 0, 0);
        check("byp_stall_valid", 64'(bus1.DE_VALID), 0);
        tick();
        drive1(0, 0, 0, 0, 0);
        check("byp_stall_count", 64'(bus1.COUNT), 1);
        check("byp_stall_pc",    64'(bus1.DE_PC), 64'h104);
        check("byp_stall_ir",    64'(bus1.DE_IR), 64'h0010_0113);
        drive1(1, 32'h108, 32'h0020_0193, 1, 0);
        check("byp_nonempty_pc", 64'(bus1.DE_PC), 64'h104);
        tick();
        drive1(0, 0, 0, 1, 0);
        check("byp_next_pc",    64'(bus1.DE_PC), 64'h108);
        check("byp_next_count", 64'(bus1.COUNT), 1);
        tick();
        check("byp_end_count", 64'(bus1.COUNT), 0);
        drive1(1, 32'h10C, 32'h0030_0213, 1, 1);
        check("byp_flush_valid", 64'(bus1.DE_VALID), 0);
        check("byp_flush_ir",    64'(bus1.DE_IR), 64'(NOP));
        tick();
        drive1(0, 0, 0, 0, 0);
        check("byp_flush_count", 64'(bus1.COUNT), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/otter_fetch_queue.md
OTTER_FETCH_QUEUE -- requirements
Module: otter_fetch_queue

Interface
REQ-001 Parameter XLEN, default 32: PC width in bits.
REQ-002 Parameter DEPTH, default 4: queue entries; a power of two, at least 2.
REQ-003 Parameter BYPASS, default 0: 1 enables the same-cycle pass-through when the queue is empty.
REQ-004 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 FLUSH  in  1  redirect from Execute (branch/jump taken); discards all queued fetches.
REQ-007 IF_VALID  in  1  fetch stage presents a fetched instruction.
REQ-008 IF_PC  in  XLEN  PC of the fetched instruction.
REQ-009 IF_IR  in  32  fetched instruction word.
REQ-010 IF_READY  out  1  queue accepts a push this cycle; drives the PC write enable.
REQ-011 DE_VALID  out  1  head entry is valid for Decode.
REQ-012 DE_PC  out  XLEN  PC of the head entry.
REQ-013 DE_IR  out  32  head instruction; 32'h00000013 (NOP) whenever DE_VALID=0.
REQ-014 DE_READY  in  1  Decode consumes the head this cycle; low means Decode is stalled.
REQ-015 COUNT  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-016 OVF_ERR  out  1  sticky flag: a push was attempted while IF_READY=0.

Function
REQ-017 Storage: circular buffer of DEPTH {pc, ir} entries; read and write pointers each carry one extra wrap bit.
REQ-018 Full/empty: full = pointer indices equal and wrap bits differ; empty = pointers identical.
REQ-019 Push: occurs when IF_VALID & IF_READY & !FLUSH; the entry is written at the write pointer, which increments modulo DEPTH and toggles its wrap bit on wrap-around.
REQ-020 Pop: occurs when DE_VALID & DE_READY & !FLUSH; the read pointer advances in the same way.
REQ-021 IF_READY = !full | DE_READY; a push into a full queue is legal only with a simultaneous pop, and COUNT then stays at DEPTH.
REQ-022 Simultaneous push and pop with 0 < COUNT < DEPTH: COUNT unchanged, FIFO order preserved.
REQ-023 Latency (BYPASS=0): an entry pushed in cycle N appears on DE_* in cycle N+1 at the earliest.
REQ-024 Bypass (BYPASS=1): when the queue is empty, IF_VALID=1, DE_READY=1 and FLUSH=0, IF_PC/IF_IR drive DE_* combinationally in the same cycle and nothing is stored.
REQ-025 Bypass with DE_READY=0: the instruction is stored normally.
REQ-026 DE_VALID = !empty (or the bypass condition) and !FLUSH; a cycle with FLUSH=1 presents a NOP to Decode.
REQ-027 FLUSH priority: FLUSH overrides push and pop in the same cycle; on the edge, both pointers clear to 0 and COUNT becomes 0.
REQ-028 After FLUSH, IF_READY=1 in the following cycle.
REQ-029 OVF_ERR sets on IF_VALID & !IF_READY & !FLUSH and holds until RESET; the rejected entry is not stored.
REQ-030 Stall: while DE_READY=0, DE_PC and DE_IR hold the head entry unchanged.
REQ-031 Non-power-of-two DEPTH: elaboration fails through a static check.

Reset
REQ-032 With RESET=1 at a rising edge: both pointers, COUNT and OVF_ERR clear to 0.
REQ-033 Following a reset edge: DE_VALID=0, DE_IR=32'h00000013, IF_READY=1.
REQ-034 RESET overrides FLUSH, push and pop; a push coincident with RESET is lost.
REQ-035 Storage contents need not be cleared on reset.

Verification
REQ-036 BYPASS=0, DEPTH=4: push PC 0x00,0x04,0x08 with DE_READY=0 -> COUNT=3; raise DE_READY -> DE_PC 0x00,0x04,0x08 on consecutive cycles, then DE_VALID=0, DE_IR=0x00000013.
REQ-037 Fill 4 entries (DE_READY=0), push 0x10 -> IF_READY=0, OVF_ERR=1, COUNT=4; then DE_READY=1 with push 0x14 -> COUNT stays 4, 0x14 is the fifth PC popped.
REQ-038 COUNT=3, FLUSH=1 with IF_VALID=1 (PC 0x40) and DE_READY=1 -> DE_VALID=0 that cycle, COUNT=0 next cycle, PC 0x40 never appears on DE_PC.
REQ-039 BYPASS=1, empty, IF_PC=0x100, IF_IR=0x00500093, DE_READY=1 -> same cycle DE_VALID=1, DE_PC=0x100, DE_IR=0x00500093, COUNT stays 0.
REQ-040 Wrap-around: run 10 continuous push+pop cycles on DEPTH=4 starting at COUNT=2 -> COUNT stays 2, popped PCs strictly sequential, no loss across pointer wrap.
REQ-041 RESET asserted with COUNT=3 and OVF_ERR=1 -> next cycle COUNT=0, OVF_ERR=0, DE_VALID=0, IF_READY=1.
